// File: rtl/fft_stage_seq.sv
// Radix-2 DIT FFT stage sequencer.
// On start, walks all N_LOG2 stages. Each stage issues N/2 butterflies
// (operand address pair + twiddle index) under valid/ready, then idles
// STAGE_GAP cycles so the downstream pipeline can drain. With CONTINUOUS=1
// the sequence restarts at stage 0 until aborted.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   start             single-cycle request to begin a transform (ignored while busy)
//   abort             synchronous cancel, highest priority
//   bfly_ready        downstream accepts the current butterfly
//   bfly_valid        addr_a/addr_b/tw_idx/stage are valid
//   addr_a, addr_b    upper / lower wing operand addresses
//   tw_idx            twiddle (coefficient) index
//   stage             current stage index
//   busy              transform in progress
//   stage_done        one-cycle pulse in the first drain cycle of every stage
//   done              one-cycle pulse in the first drain cycle of the final stage
module fft_stage_seq #(
  parameter int unsigned N_LOG2     = 3,
  parameter int unsigned STAGE_W    = 3,
  parameter int unsigned STAGE_GAP  = 1,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               abort,
  input  logic               bfly_ready,
  output logic               bfly_valid,
  output logic [N_LOG2-1:0]  addr_a,
  output logic [N_LOG2-1:0]  addr_b,
  output logic [N_LOG2-2:0]  tw_idx,
  output logic [STAGE_W-1:0] stage,
  output logic               busy,
  output logic               stage_done,
  output logic               done
);

  localparam int unsigned K_W   = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
  localparam int unsigned TW_W  = N_LOG2 - 1;
  localparam int unsigned GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [K_W-1:0]     K_LAST     = K_W'((2 ** (N_LOG2 - 1)) - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  // Butterfly address decode intermediates
  logic [N_LOG2-1:0]  k_ext;
  logic [N_LOG2-1:0]  half;
  logic [N_LOG2-1:0]  pos;
  logic [N_LOG2-1:0]  grp;
  logic [N_LOG2-1:0]  base;
  logic [N_LOG2-1:0]  tw_full;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    k_d        = k_q;
    gap_d      = gap_q;
    bfly_valid = 1'b0;
    busy       = 1'b0;
    stage_done = 1'b0;
    done       = 1'b0;
    addr_a     = '0;
    addr_b     = '0;
    tw_idx     = '0;
    stage      = stage_q;

    // k splits into group (high bits) and position within the wing (low
    // 'stage' bits); the address inserts a zero bit at position 'stage'.
    k_ext   = N_LOG2'(k_q);
    half    = N_LOG2'(1) << stage_q;
    pos     = k_ext & (half - N_LOG2'(1));
    grp     = k_ext >> stage_q;
    base    = ((grp << stage_q) << 1) | pos;
    tw_full = pos << (STAGE_LAST - stage_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stage_d = '0;
          k_d     = '0;
          gap_d   = '0;
        end
      end

      S_RUN: begin
        busy       = 1'b1;
        bfly_valid = 1'b1;
        addr_a     = base;
        addr_b     = base + half;
        tw_idx     = TW_W'(tw_full);
        if (bfly_ready) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end

      S_GAP: begin
        busy = 1'b1;
        if (gap_q == '0) begin
          stage_done = 1'b1;
          done       = (stage_q == STAGE_LAST);
        end
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (stage_q == STAGE_LAST) begin
            stage_d = '0;
            state_d = (CONTINUOUS != 0) ? S_RUN : S_IDLE;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
            state_d = S_RUN;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel overrides every other transition
    if (abort) begin
      state_d = S_IDLE;
      stage_d = '0;
      k_d     = '0;
      gap_d   = '0;
    end
  end

endmodule

// File: tb/tb_fft_stage_seq.sv
// Testbench for fft_stage_seq: default instance (N=8, gap 1, single-shot)
// and a continuous instance (N=16, gap 3). Expected butterflies come from a
// textbook DIT enumeration pushed into per-instance scoreboards; monitors
// pop and compare on every accepted butterfly.
module tb_fft_stage_seq;

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
  } bfly_t;

  logic clk;
  logic rst;

  // Default instance
  logic       d_start, d_abort, d_ready;
  logic       d_valid, d_busy, d_sdone, d_done;
  logic [2:0] d_addr_a, d_addr_b, d_stage;
  logic [1:0] d_tw;

  // Continuous instance
  logic       c_start, c_abort, c_ready;
  logic       c_valid, c_busy, c_sdone, c_done;
  logic [3:0] c_addr_a, c_addr_b;
  logic [2:0] c_tw, c_stage;

  int n_vec;
  int n_err;

  bfly_t qd[$];
  bfly_t qc[$];

  fft_stage_seq #(.N_LOG2(3), .STAGE_W(3), .STAGE_GAP(1), .CONTINUOUS(0)) u_dut (
    .CLK(clk), .RST(rst), .start(d_start), .abort(d_abort), .bfly_ready(d_ready),
    .bfly_valid(d_valid), .addr_a(d_addr_a), .addr_b(d_addr_b), .tw_idx(d_tw),
    .stage(d_stage), .busy(d_busy), .stage_done(d_sdone), .done(d_done)
  );

  fft_stage_seq #(.N_LOG2(4), .STAGE_W(3), .STAGE_GAP(3), .CONTINUOUS(1)) u_cont (
    .CLK(clk), .RST(rst), .start(c_start), .abort(c_abort), .bfly_ready(c_ready),
    .bfly_valid(c_valid), .addr_a(c_addr_a), .addr_b(c_addr_b), .tw_idx(c_tw),
    .stage(c_stage), .busy(c_busy), .stage_done(c_sdone), .done(c_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: group-major DIT butterfly order, twiddle = i * N / (2*span)
  task automatic push_tf(input int nl, input bit which);
    int n;
    n = 1 << nl;
    for (int s = 0; s < nl; s++) begin
      int span;
      span = 1 << s;
      for (int j = 0; j < n; j += 2 * span) begin
        for (int i = 0; i < span; i++) begin
          bfly_t e;
          e.a  = j + i;
          e.b  = j + i + span;
          e.tw = i * (n / (2 * span));
          e.st = s;
          if (which) qc.push_back(e);
          else qd.push_back(e);
        end
      end
    end
  endtask

  // Default-instance timeline: 4 butterflies + 1 gap cycle per stage, 3 stages
  function automatic int ev_valid(input int e);
    return int'(e >= 1 && e <= 15 && ((e - 1) % 5) < 4);
  endfunction
  function automatic int ev_sdone(input int e);
    return int'(e >= 1 && e <= 15 && ((e - 1) % 5) == 4);
  endfunction
  function automatic int ev_busy(input int e);
    return int'(e >= 1 && e <= 15);
  endfunction

  // Scoreboard monitor, default instance
  bit dh;
  int dha, dhb, dht, dhs;
  always @(negedge clk) begin
    if (rst) begin
      dh = 1'b0;
    end else begin
      if (d_valid && d_ready) begin
        if (qd.size() == 0) begin
          chk("d_unexpected_bfly", 1, 0);
        end else begin
          bfly_t e;
          e = qd.pop_front();
          chk("d_addr_a", int'(d_addr_a), e.a);
          chk("d_addr_b", int'(d_addr_b), e.b);
          chk("d_tw",     int'(d_tw),     e.tw);
          chk("d_stage",  int'(d_stage),  e.st);
        end
      end
      if (dh && d_valid) begin
        chk("d_hold_a",  int'(d_addr_a), dha);
        chk("d_hold_b",  int'(d_addr_b), dhb);
        chk("d_hold_tw", int'(d_tw),     dht);
        chk("d_hold_st", int'(d_stage),  dhs);
      end
      dh  = d_valid && !d_ready;
      dha = int'(d_addr_a);
      dhb = int'(d_addr_b);
      dht = int'(d_tw);
      dhs = int'(d_stage);
    end
  end

  // Scoreboard monitor, continuous instance
  always @(negedge clk) begin
    if (!rst && c_valid && c_ready) begin
      if (qc.size() == 0) begin
        chk("c_unexpected_bfly", 1, 0);
      end else begin
        bfly_t e;
        e = qc.pop_front();
        chk("c_addr_a", int'(c_addr_a), e.a);
        chk("c_addr_b", int'(c_addr_b), e.b);
        chk("c_tw",     int'(c_tw),     e.tw);
        chk("c_stage",  int'(c_stage),  e.st);
      end
    end
  end

  task automatic drive_d(input bit st, input bit ab, input bit rd);
    @(posedge clk);
    #1;
    d_start = st;
    d_abort = ab;
    d_ready = rd;
  endtask

  // Full default transform; optional ready stall and start pulses in gap cycles
  task automatic scen_basic(input int stl_at, input int stl_len, input bit gap_start);
    int c_end;
    int e;
    c_end = 17 + stl_len;
    push_tf(3, 1'b0);
    for (int c = 0; c <= c_end; c++) begin
      bit st;
      bit rd;
      st = (c == 0) || (gap_start && (c == 5 || c == 10 || c == 15));
      rd = !(stl_len > 0 && c >= stl_at && c < stl_at + stl_len);
      drive_d(st, 1'b0, rd);
      @(negedge clk);
      if (c >= 1) begin
        if (c < stl_at) e = c;
        else if (c < stl_at + stl_len) e = stl_at;
        else e = c - stl_len;
        chk("t_valid", int'(d_valid), ev_valid(e));
        chk("t_busy",  int'(d_busy),  ev_busy(e));
        chk("t_sdone", int'(d_sdone), ev_sdone(e));
        chk("t_done",  int'(d_done),  int'(e == 15));
      end
    end
    chk("d_queue_drained", qd.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb, ns, nd, dn;
    int done_at[$];
    clk = 1'b0;
    rst = 1'b1;
    d_start = 0; d_abort = 0; d_ready = 0;
    c_start = 0; c_abort = 0; c_ready = 0;
    n_vec = 0;
    n_err = 0;

    // Reset state
    @(negedge clk);
    chk("rst_valid",  int'(d_valid),  0);
    chk("rst_busy",   int'(d_busy),   0);
    chk("rst_stage",  int'(d_stage),  0);
    chk("rst_addr_b", int'(d_addr_b), 0);
    chk("rst_done",   int'(d_done),   0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Nominal, then start pulses during gaps, then backpressure
    scen_basic(0, 0, 1'b0);
    scen_basic(0, 0, 1'b1);
    scen_basic(7, 3, 1'b0);

    // Abort at stage 1 k=1 together with start and ready
    push_tf(3, 1'b0);
    dn = 0;
    for (int c = 0; c <= 10; c++) begin
      drive_d((c == 0) || (c == 7), (c == 7), 1'b1);
      @(negedge clk);
      dn += int'(d_done);
      if (c == 8) begin
        chk("abort_busy",  int'(d_busy),  0);
        chk("abort_valid", int'(d_valid), 0);
        chk("abort_stage", int'(d_stage), 0);
        chk("abort_sdone", int'(d_sdone), 0);
        qd.delete();
      end
      if (c > 8) chk("abort_idle", int'(d_busy), 0);
    end
    chk("abort_no_done", dn, 0);

    // start and abort together in IDLE: abort wins
    drive_d(1'b1, 1'b1, 1'b1);
    drive_d(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("idle_abort_start", int'(d_busy), 0);

    scen_basic(0, 0, 1'b0);

    // Continuous instance: done every 44 cycles, extra start ignored, abort stops
    for (int t = 0; t < 4; t++) push_tf(4, 1'b1);
    for (int c = 0; c <= 155; c++) begin
      @(posedge clk);
      #1;
      c_start = (c == 0) || (c == 60);
      c_abort = (c == 150);
      c_ready = 1'b1;
      @(negedge clk);
      if (c_done) done_at.push_back(c);
      if (c == 44 || c == 88 || c == 132) begin
        chk("c_gap_busy",  int'(c_busy),  1);
        chk("c_gap_valid", int'(c_valid), 0);
      end
      if (c == 45 || c == 89 || c == 133) begin
        chk("c_wrap_valid", int'(c_valid), 1);
        chk("c_wrap_stage", int'(c_stage), 0);
      end
      if (c >= 151) begin
        chk("c_abort_busy",  int'(c_busy),  0);
        chk("c_abort_valid", int'(c_valid), 0);
      end
    end
    chk("c_done_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      chk("c_done_first", done_at[0], 42);
      chk("c_done_gap1",  done_at[1] - done_at[0], 44);
      chk("c_done_gap2",  done_at[2] - done_at[1], 44);
    end
    qc.delete();
    c_start = 1'b0;
    c_abort = 1'b0;

    // Asynchronous reset in the middle of stage 2
    push_tf(3, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      drive_d(c == 0, 1'b0, 1'b1);
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",  int'(d_valid),  0);
    chk("arst_busy",   int'(d_busy),   0);
    chk("arst_stage",  int'(d_stage),  0);
    chk("arst_addr_a", int'(d_addr_a), 0);
    chk("arst_addr_b", int'(d_addr_b), 0);
    chk("arst_tw",     int'(d_tw),     0);
    chk("arst_sdone",  int'(d_sdone),  0);
    chk("arst_done",   int'(d_done),   0);
    qd.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive_d(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("arst_stay_idle", int'(d_busy), 0);
    end

    // Random backpressure and stray start pulses while busy
    for (int t = 0; t < 8; t++) begin
      push_tf(3, 1'b0);
      drive_d(1'b1, 1'b0, ($urandom_range(0, 3) != 0));
      @(negedge clk);
      nb = 0; ns = 0; nd = 0;
      for (int c = 1; c < 200; c++) begin
        drive_d(($urandom_range(0, 7) == 0), 1'b0, ($urandom_range(0, 3) != 0));
        @(negedge clk);
        if (!d_busy) begin
          d_start = 1'b0;
          break;
        end
        nb++;
        if (d_valid && !d_ready) ns++;
        nd += int'(d_done);
      end
      chk("rand_busy_cycles", nb, 15 + ns);
      chk("rand_done_count",  nd, 1);
      chk("rand_queue_drained", qd.size(), 0);
    end

    chk("final_qc_empty", qc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
